jtag_tap_driver: RTL and testbench

//  JTAG host-side sequencer: the initiator end of the TAP protocol. Converts

---
 rtl/jtag_tap_driver.sv | 223 ++++++++++++++++++++++
 tb/tb_jtag_tap_driver.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/jtag_tap_driver.sv
// JTAG host-side sequencer: turns RESET/IDLE/SHIFT_IR/SHIFT_DR commands into TMS/TDI
// streams on TCK, captures TDO and mirrors the target TAP state.
module jtag_tap_driver #(
    parameter int DATA_W = 32,
    parameter int LEN_W  = 6
) (
    input  logic              clk_i,
    input  logic              TRST_i,
    input  logic              cmd_valid_i,
    output logic              cmd_ready_o,
    input  logic [1:0]        cmd_op_i,
    input  logic [LEN_W-1:0]  cmd_len_i,
    input  logic [DATA_W-1:0] cmd_data_i,
    input  logic              TDO_i,
    output logic              TMS_o,
    output logic              TDI_o,
    output logic              rsp_valid_o,
    output logic [DATA_W-1:0] rsp_data_o,
    output logic              busy_o,
    output logic [3:0]        tap_state_o
);

    localparam int IDX_W = $clog2(DATA_W);

    localparam logic [1:0] OP_RESET    = 2'b00;
    localparam logic [1:0] OP_IDLE     = 2'b01;
    localparam logic [1:0] OP_SHIFT_IR = 2'b10;

    localparam logic [3:0] TLR    = 4'h0;
    localparam logic [3:0] RTI    = 4'h1;
    localparam logic [3:0] SEL_DR = 4'h2;
    localparam logic [3:0] CAP_DR = 4'h3;
    localparam logic [3:0] SH_DR  = 4'h4;
    localparam logic [3:0] EX1_DR = 4'h5;
    localparam logic [3:0] PA_DR  = 4'h6;
    localparam logic [3:0] EX2_DR = 4'h7;
    localparam logic [3:0] UPD_DR = 4'h8;
    localparam logic [3:0] SEL_IR = 4'h9;
    localparam logic [3:0] CAP_IR = 4'hA;
    localparam logic [3:0] SH_IR  = 4'hB;
    localparam logic [3:0] EX1_IR = 4'hC;
    localparam logic [3:0] PA_IR  = 4'hD;
    localparam logic [3:0] EX2_IR = 4'hE;
    localparam logic [3:0] UPD_IR = 4'hF;

    typedef enum logic [2:0] {
        S_IDLE,
        S_PREFIX,
        S_NAV,
        S_SHIFT,
        S_EXIT,
        S_DONE
    } state_e;

    function automatic logic [3:0] tap_next_state(input logic [3:0] s, input logic tms);
        logic [3:0] nxt;
        case (s)
            TLR:    nxt = tms ? TLR    : RTI;
            RTI:    nxt = tms ? SEL_DR : RTI;
            SEL_DR: nxt = tms ? SEL_IR : CAP_DR;
            CAP_DR: nxt = tms ? EX1_DR : SH_DR;
            SH_DR:  nxt = tms ? EX1_DR : SH_DR;
            EX1_DR: nxt = tms ? UPD_DR : PA_DR;
            PA_DR:  nxt = tms ? EX2_DR : PA_DR;
            EX2_DR: nxt = tms ? UPD_DR : SH_DR;
            UPD_DR: nxt = tms ? SEL_DR : RTI;
            SEL_IR: nxt = tms ? TLR    : CAP_IR;
            CAP_IR: nxt = tms ? EX1_IR : SH_IR;
            SH_IR:  nxt = tms ? EX1_IR : SH_IR;
            EX1_IR: nxt = tms ? UPD_IR : PA_IR;
            PA_IR:  nxt = tms ? EX2_IR : PA_IR;
            EX2_IR: nxt = tms ? UPD_IR : SH_IR;
            UPD_IR: nxt = tms ? SEL_DR : RTI;
            default: nxt = TLR;
        endcase
        return nxt;
    endfunction

    state_e            state_q;
    logic              tms_q;
    logic              tdi_q;
    logic              cmd_ready_q;
    logic              rsp_valid_q;
    logic [DATA_W-1:0] rsp_data_q;
    logic              busy_q;
    logic [3:0]        tap_state_q;
    logic [1:0]        op_q;
    logic [LEN_W-1:0]  len_q;
    logic [LEN_W-1:0]  cnt_q;
    logic [DATA_W-1:0] data_q;
    logic [DATA_W-1:0] cap_q;

    logic [3:0]        tap_state_d;
    logic [LEN_W-1:0]  len_d;

    // tap_state_d is where the TAP lands on this edge, so decisions made now
    // set the TMS/TDI that the following edge will consume.
    always_comb begin
        tap_state_d = tap_next_state(tap_state_q, tms_q);
        if (cmd_len_i == '0) begin
            len_d = LEN_W'(1);
        end else if (cmd_len_i > LEN_W'(DATA_W)) begin
            len_d = LEN_W'(DATA_W);
        end else begin
            len_d = cmd_len_i;
        end
    end

    always_ff @(posedge clk_i or negedge TRST_i) begin
        if (!TRST_i) begin
            state_q     <= S_IDLE;
            tms_q       <= 1'b1;
            tdi_q       <= 1'b0;
            cmd_ready_q <= 1'b1;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
            busy_q      <= 1'b0;
            tap_state_q <= TLR;
            op_q        <= OP_RESET;
            len_q       <= '0;
            cnt_q       <= '0;
            data_q      <= '0;
            cap_q       <= '0;
        end else begin
            tap_state_q <= tap_state_d;
            rsp_valid_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (cmd_valid_i) begin
                        op_q        <= cmd_op_i;
                        len_q       <= len_d;
                        data_q      <= cmd_data_i;
                        cap_q       <= '0;
                        cnt_q       <= '0;
                        busy_q      <= 1'b1;
                        cmd_ready_q <= 1'b0;
                        if (tap_state_q == TLR && cmd_op_i != OP_RESET) begin
                            tms_q   <= 1'b0;
                            state_q <= S_PREFIX;
                        end else begin
                            tms_q   <= (cmd_op_i != OP_IDLE);
                            state_q <= S_NAV;
                        end
                    end
                end
                S_PREFIX: begin
                    tms_q   <= (op_q != OP_IDLE);
                    state_q <= S_NAV;
                end
                S_NAV: begin
                    case (op_q)
                        OP_RESET: begin
                            if (cnt_q == LEN_W'(4)) begin
                                tms_q   <= 1'b0;
                                state_q <= S_EXIT;
                            end else begin
                                tms_q <= 1'b1;
                                cnt_q <= cnt_q + LEN_W'(1);
                            end
                        end
                        OP_IDLE: begin
                            if (cnt_q == len_q - LEN_W'(1)) begin
                                state_q <= S_DONE;
                            end else begin
                                cnt_q <= cnt_q + LEN_W'(1);
                            end
                        end
                        default: begin
                            case (tap_state_d)
                                SEL_DR: tms_q <= (op_q == OP_SHIFT_IR);
                                SH_DR, SH_IR: begin
                                    tdi_q   <= data_q[0];
                                    tms_q   <= (len_q == LEN_W'(1));
                                    state_q <= S_SHIFT;
                                end
                                default: tms_q <= 1'b0;
                            endcase
                        end
                    endcase
                end
                S_SHIFT: begin
                    cap_q[cnt_q[IDX_W-1:0]] <= TDO_i;
                    if (cnt_q == len_q - LEN_W'(1)) begin
                        tms_q   <= 1'b1;
                        tdi_q   <= 1'b0;
                        state_q <= S_EXIT;
                    end else begin
                        tdi_q  <= data_q[1];
                        data_q <= data_q >> 1;
                        tms_q  <= (cnt_q + LEN_W'(2) == len_q);
                        cnt_q  <= cnt_q + LEN_W'(1);
                    end
                end
                S_EXIT: begin
                    if (tap_state_d == RTI) begin
                        state_q     <= S_DONE;
                        rsp_valid_q <= op_q[1];
                        if (op_q[1]) begin
                            rsp_data_q <= cap_q;
                        end
                    end else begin
                        tms_q <= 1'b0;
                    end
                end
                S_DONE: begin
                    state_q     <= S_IDLE;
                    busy_q      <= 1'b0;
                    cmd_ready_q <= 1'b1;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign cmd_ready_o = cmd_ready_q;
    assign TMS_o       = tms_q;
    assign TDI_o       = tdi_q;
    assign rsp_valid_o = rsp_valid_q;
    assign rsp_data_o  = rsp_data_q;
    assign busy_o      = busy_q;
    assign tap_state_o = tap_state_q;

endmodule

// File: tb/tb_jtag_tap_driver.sv
// Self-checking bench for jtag_tap_driver: behavioural TAP in lockstep, TMS/TDI stream
// expectations per command, and a response scoreboard fed with TDO looped back from TDI.
module tb_jtag_tap_driver;

    localparam int DATA_W = 32;
    localparam int LEN_W  = 6;

    logic              clk;
    logic              trstN;
    logic              cmdValid;
    logic              cmdReady;
    logic [1:0]        cmdOp;
    logic [LEN_W-1:0]  cmdLen;
    logic [DATA_W-1:0] cmdData;
    logic              tdo;
    logic              tms;
    logic              tdi;
    logic              rspValid;
    logic [DATA_W-1:0] rspData;
    logic              busy;
    logic [3:0]        tapState;

    bit                tdoInvert;
    bit                monitorOn;
    logic [3:0]        modelState;
    logic [DATA_W-1:0] sbQueue[$];
    logic [DATA_W-1:0] lastRsp;
    int                compareCount;
    int                mismatchCount;

    jtag_tap_driver #(.DATA_W(DATA_W), .LEN_W(LEN_W)) dut (
        .clk_i       (clk),
        .TRST_i      (trstN),
        .cmd_valid_i (cmdValid),
        .cmd_ready_o (cmdReady),
        .cmd_op_i    (cmdOp),
        .cmd_len_i   (cmdLen),
        .cmd_data_i  (cmdData),
        .TDO_i       (tdo),
        .TMS_o       (tms),
        .TDI_o       (tdi),
        .rsp_valid_o (rspValid),
        .rsp_data_o  (rspData),
        .busy_o      (busy),
        .tap_state_o (tapState)
    );

    assign tdo = tdi ^ tdoInvert;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [3:0] tapStep(input logic [3:0] s, input logic m);
        logic [3:0] n;
        case (s)
            4'h0: n = m ? 4'h0 : 4'h1;
            4'h1: n = m ? 4'h2 : 4'h1;
            4'h2: n = m ? 4'h9 : 4'h3;
            4'h3: n = m ? 4'h5 : 4'h4;
            4'h4: n = m ? 4'h5 : 4'h4;
            4'h5: n = m ? 4'h8 : 4'h6;
            4'h6: n = m ? 4'h7 : 4'h6;
            4'h7: n = m ? 4'h8 : 4'h4;
            4'h8: n = m ? 4'h2 : 4'h1;
            4'h9: n = m ? 4'h0 : 4'hA;
            4'hA: n = m ? 4'hC : 4'hB;
            4'hB: n = m ? 4'hC : 4'hB;
            4'hC: n = m ? 4'hF : 4'hD;
            4'hD: n = m ? 4'hE : 4'hD;
            4'hE: n = m ? 4'hF : 4'hB;
            default: n = m ? 4'h2 : 4'h1;
        endcase
        return n;
    endfunction

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        compareCount++;
        if (observed !== expected) begin
            mismatchCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, observed, expected, $time);
        end
    endtask

    // Reference TAP, clocked by the same TMS the target would see.
    always @(posedge clk or negedge trstN) begin
        if (!trstN) modelState <= 4'h0;
        else        modelState <= tapStep(modelState, tms);
    end

    always @(negedge clk) begin
        if (monitorOn) begin
            checkOutput("tap_state", 64'(tapState), 64'(modelState));
            if (rspValid) begin
                if (sbQueue.size() == 0) begin
                    checkOutput("rsp_unexpected", 64'(1), 64'(0));
                end else begin
                    checkOutput("rsp_data", 64'(rspData), 64'(sbQueue.pop_front()));
                end
            end
        end
    end

    task automatic resetDut();
        trstN    = 1'b0;
        cmdValid = 1'b0;
        repeat (2) @(negedge clk);
        checkOutput("rst_tms", 64'(tms), 64'(1));
        checkOutput("rst_tdi", 64'(tdi), 64'(0));
        checkOutput("rst_ready", 64'(cmdReady), 64'(1));
        checkOutput("rst_rsp_valid", 64'(rspValid), 64'(0));
        checkOutput("rst_rsp_data", 64'(rspData), 64'(0));
        checkOutput("rst_busy", 64'(busy), 64'(0));
        checkOutput("rst_tap_state", 64'(tapState), 64'(0));
        trstN   = 1'b1;
        lastRsp = '0;
        @(negedge clk);
    endtask

    // Issues one command (called on a negedge) and checks its whole TMS/TDI stream.
    task automatic applyStimulus(input logic [1:0] op, input logic [LEN_W-1:0] len,
                                 input logic [DATA_W-1:0] data, input bit noisy,
                                 output logic [63:0] path);
        int guard, effLen, n, cycles, shiftCnt, rspCycle;
        bit prefix, isShift;
        logic [63:0] expTms, tmsObs, tdiObs, mask, expRsp;
        logic [3:0] lastState;
        guard = 0;
        while (!cmdReady && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        checkOutput("ready_wait", 64'(cmdReady), 64'(1));
        effLen  = (len == 0) ? 1 : ((int'(len) > DATA_W) ? DATA_W : int'(len));
        isShift = op[1];
        prefix  = (modelState == 4'h0) && (op != 2'b00);
        expTms  = '0;
        n       = 0;
        if (prefix) begin expTms[n] = 1'b0; n++; end
        case (op)
            2'b00: begin
                for (int i = 0; i < 5; i++) begin expTms[n] = 1'b1; n++; end
                expTms[n] = 1'b0; n++;
            end
            2'b01: begin
                for (int i = 0; i < effLen; i++) begin expTms[n] = 1'b0; n++; end
            end
            default: begin
                expTms[n] = 1'b1; n++;
                if (op == 2'b10) begin expTms[n] = 1'b1; n++; end
                expTms[n] = 1'b0; n++;
                expTms[n] = 1'b0; n++;
                for (int i = 0; i < effLen - 1; i++) begin expTms[n] = 1'b0; n++; end
                expTms[n] = 1'b1; n++;
                expTms[n] = 1'b1; n++;
                expTms[n] = 1'b0; n++;
            end
        endcase
        mask   = (effLen >= DATA_W) ? 64'hFFFF_FFFF : ((64'd1 << effLen) - 64'd1);
        expRsp = ({32'd0, data} ^ (tdoInvert ? 64'hFFFF_FFFF : 64'd0)) & mask;
        if (isShift) sbQueue.push_back(expRsp[DATA_W-1:0]);

        cmdValid = 1'b1;
        cmdOp    = op;
        cmdLen   = len;
        cmdData  = data;
        @(negedge clk);
        cmdValid  = 1'b0;
        cycles    = 0;
        shiftCnt  = 0;
        rspCycle  = -1;
        tmsObs    = '0;
        tdiObs    = '0;
        path      = '0;
        lastState = 4'h0;
        while (busy && cycles < 200) begin
            if (cycles == 0) checkOutput("ready_low", 64'(cmdReady), 64'(0));
            if (cycles < 64) tmsObs[cycles] = tms;
            if ((modelState == 4'h4 || modelState == 4'hB) && shiftCnt < 64) begin
                tdiObs[shiftCnt] = tdi;
                shiftCnt++;
            end
            if (cycles == 0 || tapState != lastState) path = (path << 4) | 64'(tapState);
            lastState = tapState;
            if (rspValid) rspCycle = cycles;
            if (noisy) begin
                cmdValid = 1'($urandom_range(0, 1));
                cmdOp    = 2'($urandom_range(0, 3));
                cmdLen   = LEN_W'($urandom_range(0, 63));
                cmdData  = $urandom;
            end
            @(negedge clk);
            cycles++;
        end
        cmdValid = 1'b0;
        checkOutput("busy_cycles", 64'(cycles), 64'(n + 1));
        checkOutput("tms_seq", tmsObs & ((64'd1 << n) - 64'd1), expTms);
        if (isShift) begin
            checkOutput("shift_len", 64'(shiftCnt), 64'(effLen));
            checkOutput("tdi_bits", tdiObs, {32'd0, data} & mask);
            checkOutput("rsp_cycle", 64'(rspCycle), 64'(n));
            lastRsp = expRsp[DATA_W-1:0];
        end
        checkOutput("rsp_hold", 64'(rspData), 64'(lastRsp));
    endtask

    initial begin
        logic [63:0] path;
        compareCount  = 0;
        mismatchCount = 0;
        trstN     = 1'b1;
        cmdValid  = 1'b0;
        cmdOp     = 2'b00;
        cmdLen    = '0;
        cmdData   = '0;
        tdoInvert = 1'b0;
        lastRsp   = '0;
        #1;
        trstN     = 1'b0;
        monitorOn = 1'b1;
        @(negedge clk);
        resetDut();

        applyStimulus(2'b00, 6'd0, 32'h0, 1'b0, path);
        checkOutput("reset_cmd_end", 64'(tapState), 64'(1));

        applyStimulus(2'b11, 6'd8, 32'h0000_00A5, 1'b0, path);
        checkOutput("dr8_rsp", 64'(rspData), 64'h0000_00A5);

        resetDut();
        applyStimulus(2'b10, 6'd4, 32'h0000_000F, 1'b0, path);
        checkOutput("ir4_path", path, 64'h0000_0000_129A_BCF1);

        applyStimulus(2'b11, 6'd0, 32'hFFFF_FFFF, 1'b0, path);
        applyStimulus(2'b11, 6'd40, 32'hDEAD_BEEF, 1'b0, path);
        tdoInvert = 1'b1;
        applyStimulus(2'b10, 6'd32, 32'h1234_5678, 1'b0, path);
        tdoInvert = 1'b0;
        applyStimulus(2'b01, 6'd3, 32'h0, 1'b0, path);

        // Pull TRST in the middle of a DR shift; the command must vanish silently.
        cmdValid = 1'b1;
        cmdOp    = 2'b11;
        cmdLen   = 6'd20;
        cmdData  = 32'h0BAD_F00D;
        @(negedge clk);
        cmdValid = 1'b0;
        repeat (8) @(negedge clk);
        trstN = 1'b0;
        #1;
        checkOutput("trst_tms", 64'(tms), 64'(1));
        checkOutput("trst_tdi", 64'(tdi), 64'(0));
        checkOutput("trst_ready", 64'(cmdReady), 64'(1));
        checkOutput("trst_rsp_valid", 64'(rspValid), 64'(0));
        checkOutput("trst_rsp_data", 64'(rspData), 64'(0));
        checkOutput("trst_busy", 64'(busy), 64'(0));
        checkOutput("trst_tap_state", 64'(tapState), 64'(0));
        @(negedge clk);
        trstN   = 1'b1;
        lastRsp = '0;
        repeat (30) @(negedge clk);
        checkOutput("trst_idle_busy", 64'(busy), 64'(0));
        checkOutput("trst_idle_state", 64'(tapState), 64'(0));

        for (int i = 0; i < 200; i++) begin
            tdoInvert = 1'($urandom_range(0, 1));
            applyStimulus(2'($urandom_range(0, 3)), LEN_W'($urandom_range(0, 63)), $urandom, 1'b1, path);
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end

        repeat (5) @(negedge clk);
        checkOutput("sb_empty", 64'(sbQueue.size()), 64'(0));
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
        $finish;
    end

endmodule
